// File: rtl/game_pkg.sv
// Shared types and helpers for the memory-game blocks: symbol type,
// sequence-engine state encoding, one-hot LED decode and LFSR taps.
package game_pkg;

  typedef logic [1:0] sym_t;

  typedef enum logic [2:0] {
    IDLE,
    APPEND,
    PLAY_ON,
    PLAY_OFF,
    COLLECT
  } state_t;

  // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [3:0] onehot4(input sym_t s);
    onehot4 = 4'b0001 << s;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; reloads SEED on synchronous reset.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (reset) state <= SEED;
    else       state <= {state[14:0], ^(state & LFSR_TAPS)};
  end

endmodule

// File: rtl/sequence_engine.sv
// Memory-game sequence engine: appends LFSR symbols, plays them on one-hot LEDs,
// scores player entries. Define SEQUENCE_ENGINE_ECHO_EN for LED echo of presses.
module sequence_engine
  import game_pkg::*;
#(
  parameter int          MAX_LEN   = 16,
  parameter int          ON_TICKS  = 25_000_000,
  parameter int          OFF_TICKS = 12_500_000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             seq_ld,
  input  logic                             entry_valid,
  input  logic [1:0]                       entry_sym,
  input  logic                             check,
  output logic [3:0]                       led,
  output logic                             busy,
  output logic                             play_done,
  output logic                             seq_check,
  output logic [$clog2(MAX_LEN+1)-1:0]     seq_len
);

  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int IW   = $clog2(MAX_LEN);
  localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  logic [15:0] lfsr_state;
  logic        unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr_state)
  );

  assign unused_lfsr = ^lfsr_state[15:2];

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic [LW-1:0]   ecnt_q, ecnt_d;
  logic [LW-1:0]   len_d;
  logic            mis_q, mis_d;
  logic [3:0]      led_d;
  logic            busy_d, done_d, chk_d;
  logic            mem_we;
  sym_t            first_sym;
  sym_t            mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (mem_we) mem[seq_len[IW-1:0]] <= lfsr_state[1:0];
  end

  // The first symbol may be written in the same APPEND cycle it is displayed.
  assign first_sym = (seq_len == '0) ? lfsr_state[1:0] : mem[0];

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    ecnt_d  = ecnt_q;
    mis_d   = mis_q;
    len_d   = seq_len;
    led_d   = led;
    chk_d   = seq_check;
    done_d  = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (seq_ld) begin
          state_d = APPEND;
          chk_d   = 1'b0;
        end
      end
      APPEND: begin
        if (seq_len < LW'(MAX_LEN)) begin
          mem_we = 1'b1;
          len_d  = seq_len + 1'b1;
        end
        idx_d   = '0;
        tick_d  = '0;
        led_d   = onehot4(first_sym);
        state_d = PLAY_ON;
      end
      PLAY_ON: begin
        if (tick_q == TW'(ON_TICKS - 1)) begin
          tick_d  = '0;
          led_d   = '0;
          state_d = PLAY_OFF;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      PLAY_OFF: begin
        if (tick_q == TW'(OFF_TICKS - 1)) begin
          tick_d = '0;
          idx_d  = idx_q + 1'b1;
          if (idx_d == seq_len) begin
            state_d = COLLECT;
            done_d  = 1'b1;
            ecnt_d  = '0;
            mis_d   = 1'b0;
          end else begin
            state_d = PLAY_ON;
            led_d   = onehot4(mem[idx_d[IW-1:0]]);
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      COLLECT: begin
`ifdef SEQUENCE_ENGINE_ECHO_EN
        if (led != '0) begin
          if (tick_q == TW'(ON_TICKS - 1)) begin
            led_d  = '0;
            tick_d = '0;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
`endif
        if (entry_valid) begin
          if (ecnt_q < seq_len) begin
            if (entry_sym != mem[ecnt_q[IW-1:0]]) mis_d = 1'b1;
            ecnt_d = ecnt_q + 1'b1;
          end else begin
            mis_d = 1'b1;
          end
`ifdef SEQUENCE_ENGINE_ECHO_EN
          led_d  = onehot4(entry_sym);
          tick_d = '0;
`endif
        end
        // Verdict uses the post-entry count/flag so a same-cycle press is scored.
        if (seq_ld) begin
          state_d = APPEND;
          chk_d   = 1'b0;
          led_d   = '0;
        end else if (check) begin
          chk_d   = !mis_d && (ecnt_d == seq_len);
          state_d = IDLE;
          led_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d = IDLE;
      len_d   = '0;
      chk_d   = 1'b0;
      led_d   = '0;
      tick_d  = '0;
      idx_d   = '0;
      ecnt_d  = '0;
      mis_d   = 1'b0;
      done_d  = 1'b0;
      mem_we  = 1'b0;
    end

    busy_d = (state_d == APPEND) || (state_d == PLAY_ON) || (state_d == PLAY_OFF);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      idx_q     <= '0;
      ecnt_q    <= '0;
      mis_q     <= 1'b0;
      seq_len   <= '0;
      led       <= '0;
      busy      <= 1'b0;
      play_done <= 1'b0;
      seq_check <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      idx_q     <= idx_d;
      ecnt_q    <= ecnt_d;
      mis_q     <= mis_d;
      seq_len   <= len_d;
      led       <= led_d;
      busy      <= busy_d;
      play_done <= done_d;
      seq_check <= chk_d;
    end
  end

endmodule
